tube_collision_score: RTL



---
 rtl/flappy_pkg.sv | 52 +++++
 rtl/tube_hit_check.sv | 33 +++
 rtl/tube_collision_score.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/flappy_pkg.sv
// Shared game definitions: state encoding, screen/tube/bird geometry and
// the BCD score helpers used by the collision/score block.
package flappy_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DEAD = 2'd2
   } game_state_t;

   localparam int NUM_TUBES = 3;

   // Geometry is carried as 12-bit unsigned so sums never wrap.
   localparam logic [11:0] SCREEN_WIDTH  = 12'd1024;
   localparam logic [11:0] SCREEN_HEIGHT = 12'd768;
   localparam logic [11:0] TUBE_WIDTH    = 12'd60;
   localparam logic [11:0] GAP_HEIGHT    = 12'd600;
   localparam logic [11:0] BIRD_X        = 12'd200;
   localparam logic [11:0] BIRD_SIZE     = 12'd32;
   localparam logic [4:0]  DEAD_FRAMES   = 5'd30;

   // Add one to a 3-digit BCD value, sticking at 999.
   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [11:0] r;
      r = v;
      if (v != 12'h999) begin
         if (r[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            if (r[7:4] == 4'd9) begin
               r[7:4]  = 4'd0;
               r[11:8] = r[11:8] + 4'd1;
            end else begin
               r[7:4] = r[7:4] + 4'd1;
            end
         end else begin
            r[3:0] = r[3:0] + 4'd1;
         end
      end
      return r;
   endfunction

   // Add 0..3 to a BCD score with saturation at 999.
   function automatic logic [11:0] bcd_add(input logic [11:0] v, input logic [1:0] n);
      logic [11:0] r;
      r = v;
      for (int i = 0; i < 3; i++) begin
         if (i < int'(n)) r = bcd_inc(r);
      end
      return r;
   endfunction

endpackage

// File: rtl/tube_hit_check.sv
// Combinational geometry check of the bird box against one tube.
// Time-shared by the top across all tubes.
module tube_hit_check
   import flappy_pkg::*;
(
   input  logic [10:0] tube_x,
   input  logic [10:0] gap_y,
   input  logic [10:0] bird_y,
   output logic        collide,
   output logic        pass_cond,
   output logic        wrap_cond
);

   logic [11:0] tx;
   logic [11:0] gy;
   logic [11:0] by;
   logic        h_overlap;
   logic        v_safe;

   assign tx = {1'b0, tube_x};
   assign gy = {1'b0, gap_y};
   assign by = {1'b0, bird_y};

   // tube_x is the exclusive right edge; compare against widened bird span
   // instead of subtracting tube coordinates.
   assign h_overlap = (BIRD_X < tx) && ((BIRD_X + BIRD_SIZE + TUBE_WIDTH) > tx);
   assign v_safe    = (by >= gy) && ((by + BIRD_SIZE) <= (gy + GAP_HEIGHT));

   assign collide   = h_overlap && !v_safe;
   assign pass_cond = (tx <= BIRD_X);
   assign wrap_cond = (tx > (BIRD_X + BIRD_SIZE));

endmodule

// File: rtl/tube_collision_score.sv
// Per-frame collision evaluation, game state machine and BCD score.
// A frame_tick snapshots the inputs, three cycles check one tube each,
// and the fifth cycle commits state/score/pass flags.
module tube_collision_score
   import flappy_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        game_rst,
   input  logic        frame_tick,
   input  logic        flap,
   input  logic [10:0] bird_y,
   input  logic [10:0] tube_x [2:0],
   input  logic [10:0] gap_y [2:0],
   output logic [1:0]  game_state,
   output logic        hit,
   output logic        score_pulse,
   output logic [11:0] score_bcd,
   output logic        restart_req
);

   game_state_t state;
   logic        busy;
   logic [1:0]  phase;
   logic [10:0] snap_bird_y;
   logic [10:0] snap_tube_x [2:0];
   logic [10:0] snap_gap_y [2:0];
   logic        coll_acc;
   logic [2:0]  pass_req;
   logic [2:0]  wrap_req;
   logic [2:0]  passed;
   logic [4:0]  dead_cnt;
   logic [1:0]  chk_idx;
   logic        collide;
   logic        pass_cond;
   logic        wrap_cond;
   logic        bounds_hit;
   logic        commit;
   logic [1:0]  pass_cnt;

   assign game_state = state;
   assign chk_idx    = (phase == 2'd3) ? 2'd0 : phase;
   assign commit     = busy && (phase == 2'd3);
   assign bounds_hit = (({1'b0, snap_bird_y}) + BIRD_SIZE) > SCREEN_HEIGHT;
   assign pass_cnt   = {1'b0, pass_req[0]} + {1'b0, pass_req[1]} + {1'b0, pass_req[2]};

   tube_hit_check u_check (
      .tube_x    (snap_tube_x[chk_idx]),
      .gap_y     (snap_gap_y[chk_idx]),
      .bird_y    (snap_bird_y),
      .collide   (collide),
      .pass_cond (pass_cond),
      .wrap_cond (wrap_cond)
   );

   // Per-tube input snapshot taken on an accepted frame_tick.
   for (genvar gi = 0; gi < NUM_TUBES; gi++) begin : g_snap
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            snap_tube_x[gi] <= '0;
            snap_gap_y[gi]  <= '0;
         end else if (game_rst) begin
            snap_tube_x[gi] <= '0;
            snap_gap_y[gi]  <= '0;
         end else if (frame_tick && !busy) begin
            snap_tube_x[gi] <= tube_x[gi];
            snap_gap_y[gi]  <= gap_y[gi];
         end
      end
   end

   // Evaluation sequencer, pass flags, game FSM and score.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         phase       <= 2'd0;
         snap_bird_y <= '0;
         coll_acc    <= 1'b0;
         pass_req    <= '0;
         wrap_req    <= '0;
         passed      <= '0;
         dead_cnt    <= '0;
         score_bcd   <= '0;
         hit         <= 1'b0;
         score_pulse <= 1'b0;
         restart_req <= 1'b0;
      end else if (game_rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         phase       <= 2'd0;
         snap_bird_y <= '0;
         coll_acc    <= 1'b0;
         pass_req    <= '0;
         wrap_req    <= '0;
         passed      <= '0;
         dead_cnt    <= '0;
         score_bcd   <= '0;
         hit         <= 1'b0;
         score_pulse <= 1'b0;
         restart_req <= 1'b0;
      end else begin
         hit         <= 1'b0;
         score_pulse <= 1'b0;
         restart_req <= 1'b0;

         if (frame_tick && (state == DEAD) && (dead_cnt != DEAD_FRAMES))
            dead_cnt <= dead_cnt + 5'd1;

         if (!busy) begin
            if (frame_tick) begin
               busy        <= 1'b1;
               phase       <= 2'd0;
               snap_bird_y <= bird_y;
               coll_acc    <= 1'b0;
               pass_req    <= '0;
               wrap_req    <= '0;
            end
         end else if (!commit) begin
            coll_acc        <= coll_acc | collide;
            pass_req[phase] <= pass_cond && !passed[phase];
            wrap_req[phase] <= wrap_cond;
            phase           <= phase + 2'd1;
         end else begin
            busy   <= 1'b0;
            passed <= (passed | pass_req) & ~wrap_req;
         end

         case (state)
            IDLE: begin
               if (flap) state <= RUN;
            end
            RUN: begin
               if (commit) begin
                  if (coll_acc || bounds_hit) begin
                     state    <= DEAD;
                     hit      <= 1'b1;
                     dead_cnt <= '0;
                  end else if (pass_cnt != 2'd0) begin
                     score_bcd   <= bcd_add(score_bcd, pass_cnt);
                     score_pulse <= 1'b1;
                  end
               end
            end
            DEAD: begin
               if (flap && (dead_cnt == DEAD_FRAMES)) begin
                  state       <= IDLE;
                  restart_req <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
